// File: rtl/io_pkg.sv
// Shared constants for the GPIO input sampler: port geometry, synchroniser limits
// and INT0 edge-select encodings.
package io_pkg;

    localparam int PORT_W    = 8;
    localparam int NUM_PORTS = 3;
    localparam int SYNC_MIN  = 2;
    localparam int SYNC_MAX  = 3;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    typedef enum logic [1:0] {
        PORT_A = 2'd0,
        PORT_B = 2'd1,
        PORT_C = 2'd2
    } port_e;

    // Counter width that holds 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    function automatic int clamp_sync(input int stages);
        if (stages < SYNC_MIN) return SYNC_MIN;
        if (stages > SYNC_MAX) return SYNC_MAX;
        return stages;
    endfunction

endpackage

// File: rtl/io_pin_sync_debounce.sv
// One pad bit: multi-flop synchroniser followed by a stable-count debouncer.
// DEBOUNCE_CYCLES = 0 passes the synchronised value straight through.
module io_pin_sync_debounce
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic deb
);

    localparam int SS = clamp_sync(SYNC_STAGES);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SS-1:0] chain;
    logic          sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SS-2:0], pin};
        end
    end

    assign sync = chain[SS-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync;
        end else begin : g_filter
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          deb_q;

            // The counter clears on the accepting edge, so it tops out at CNT_LAST.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt   <= '0;
                    deb_q <= 1'b0;
                end else if (sync == deb_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb_q <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

endmodule

// File: rtl/io_port_sampler.sv
// GPIO input side: debounced pad sampling for ports A/B/C, port read data,
// INT0 edge interrupt on B[0] and the port-B[7:4] change interrupt.
module io_port_sampler
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PORT_W-1:0] pin_a,
    input  logic [PORT_W-1:0] pin_b,
    input  logic [PORT_W-1:0] pin_c,
    input  logic [PORT_W-1:0] trisa,
    input  logic [PORT_W-1:0] trisb,
    input  logic [PORT_W-1:0] trisc,
    input  logic [PORT_W-1:0] port_int_a,
    input  logic [PORT_W-1:0] port_int_b,
    input  logic [PORT_W-1:0] port_int_c,
    input  logic              intedg,
    input  logic              rb_read,
    input  logic              int0_clr,
    input  logic              rbif_clr,
    output logic [PORT_W-1:0] rd_a,
    output logic [PORT_W-1:0] rd_b,
    output logic [PORT_W-1:0] rd_c,
    output logic              int0_flag,
    output logic              rbif
);

    logic [NUM_PORTS-1:0][PORT_W-1:0] pins;
    logic [NUM_PORTS-1:0][PORT_W-1:0] debs;
    logic [PORT_W-1:0]                deb_a;
    logic [PORT_W-1:0]                deb_b;
    logic [PORT_W-1:0]                deb_c;

    assign pins[PORT_A] = pin_a;
    assign pins[PORT_B] = pin_b;
    assign pins[PORT_C] = pin_c;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            for (genvar i = 0; i < PORT_W; i++) begin : g_bit
                io_pin_sync_debounce #(
                    .SYNC_STAGES     (SYNC_STAGES),
                    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
                ) u_bit (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .pin   (pins[p][i]),
                    .deb   (debs[p][i])
                );
            end
        end
    endgenerate

    assign deb_a = debs[PORT_A];
    assign deb_b = debs[PORT_B];
    assign deb_c = debs[PORT_C];

    // Output bits read back the latch, never the pad.
    assign rd_a = (trisa & deb_a) | (~trisa & port_int_a);
    assign rd_b = (trisb & deb_b) | (~trisb & port_int_b);
    assign rd_c = (trisc & deb_c) | (~trisc & port_int_c);

    logic       int0_prev;
    logic       int0_rise;
    logic       int0_fall;
    logic       int0_hit;
    logic [3:0] rb_ref;
    logic       rb_mismatch;

    // Edge detection works on real transitions of deb_b[0], so flipping intedg
    // or trisb[0] on its own never produces an event.
    assign int0_rise   = deb_b[0] & ~int0_prev;
    assign int0_fall   = ~deb_b[0] & int0_prev;
    assign int0_hit    = trisb[0] & ((intedg == EDGE_RISE) ? int0_rise : int0_fall);
    assign rb_mismatch = |((deb_b[7:4] ^ rb_ref) & trisb[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int0_prev <= 1'b0;
            int0_flag <= 1'b0;
            rb_ref    <= '0;
            rbif      <= 1'b0;
        end else begin
            int0_prev <= deb_b[0];
            int0_flag <= int0_hit | (int0_flag & ~int0_clr);
            rbif      <= rb_mismatch | (rbif & ~rbif_clr);
            if (rb_read) begin
                rb_ref <= deb_b[7:4];
            end
        end
    end

endmodule
